// File: rtl/vga_pkg.sv
// Shared VGA definitions: timing bundle type, standard mode constants,
// colour-width helper and the default 1-bit-per-channel palette.
package vga_pkg;

    typedef struct packed {
        int unsigned active;
        int unsigned fp;
        int unsigned sync;
        int unsigned bp;
    } timing_t;

    localparam timing_t VGA_800X600_72_H = '{800, 56, 120, 64};
    localparam timing_t VGA_800X600_72_V = '{600, 37, 6, 23};
    localparam timing_t VGA_640X480_60_H = '{640, 16, 96, 48};
    localparam timing_t VGA_640X480_60_V = '{480, 10, 2, 33};

    function automatic int unsigned rgb_width(int unsigned color_bits);
        return 3 * color_bits;
    endfunction

    function automatic int unsigned span(timing_t t);
        return t.active + t.fp + t.sync + t.bp;
    endfunction

    localparam logic [2:0] MAGENTA = 3'b101;
    localparam logic [2:0] BLACK   = 3'b000;
    localparam logic [2:0] BLUE    = 3'b001;
    localparam logic [2:0] WHITE   = 3'b111;

endpackage

// File: rtl/vga_timing.sv
// Pixel/line counters plus sync, data-enable and frame-start flags.
// Ports: clk, rst; raw hcnt/vcnt; hs_active, vs_active, de, frame_start
// registered one cycle after the counter value they describe.
module vga_timing #(
    parameter int unsigned H_ACTIVE = 800,
    parameter int unsigned H_FP     = 56,
    parameter int unsigned H_SYNC   = 120,
    parameter int unsigned H_BP     = 64,
    parameter int unsigned V_ACTIVE = 600,
    parameter int unsigned V_FP     = 37,
    parameter int unsigned V_SYNC   = 6,
    parameter int unsigned V_BP     = 23,
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int unsigned HW      = $clog2(H_TOTAL),
    localparam int unsigned VW      = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          rst,
    output logic [HW-1:0] hcnt,
    output logic [VW-1:0] vcnt,
    output logic          hs_active,
    output logic          vs_active,
    output logic          de,
    output logic          frame_start
);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS  = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_VIS  = VW'(V_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic h_last;
    logic v_last;

    assign h_last = (hcnt == H_LAST);
    assign v_last = (vcnt == V_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt <= '0;
            vcnt <= '0;
        end else begin
            hcnt <= h_last ? '0 : hcnt + 1'b1;
            if (h_last)
                vcnt <= v_last ? '0 : vcnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hs_active   <= 1'b0;
            vs_active   <= 1'b0;
            de          <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hs_active   <= (hcnt >= HS_BEG) && (hcnt < HS_END);
            vs_active   <= (vcnt >= VS_BEG) && (vcnt < VS_END);
            de          <= (hcnt < H_VIS) && (vcnt < V_VIS);
            frame_start <= (hcnt == '0) && (vcnt == '0);
        end
    end

endmodule

// File: rtl/vga_grid_renderer.sv
// Renders a double-buffered cell grid with optional grid lines and cursor
// outline onto VGA pins. Ports: clk, rst, grid, cursor_x/y, cursor_en,
// lines_en in; hsync, vsync, rgb, de, frame_start out (2-cycle latency).
module vga_grid_renderer
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = VGA_800X600_72_H.active,
    parameter int unsigned H_FP       = VGA_800X600_72_H.fp,
    parameter int unsigned H_SYNC     = VGA_800X600_72_H.sync,
    parameter int unsigned H_BP       = VGA_800X600_72_H.bp,
    parameter int unsigned V_ACTIVE   = VGA_800X600_72_V.active,
    parameter int unsigned V_FP       = VGA_800X600_72_V.fp,
    parameter int unsigned V_SYNC     = VGA_800X600_72_V.sync,
    parameter int unsigned V_BP       = VGA_800X600_72_V.bp,
    parameter bit          HSYNC_POL  = 1'b1,
    parameter bit          VSYNC_POL  = 1'b1,
    parameter int unsigned CELL_SIZE  = 40,
    parameter int unsigned COLOR_BITS = 1,
    parameter int unsigned LIVE_RGB   = MAGENTA,
    parameter int unsigned DEAD_RGB   = BLACK,
    parameter int unsigned LINE_RGB   = BLUE,
    parameter int unsigned CURSOR_RGB = WHITE,
    localparam int unsigned GRID_W    = H_ACTIVE / CELL_SIZE,
    localparam int unsigned GRID_H    = V_ACTIVE / CELL_SIZE,
    localparam int unsigned CXW       = GRID_W > 1 ? $clog2(GRID_W) : 1,
    localparam int unsigned CYW       = GRID_H > 1 ? $clog2(GRID_H) : 1,
    localparam int unsigned CB3       = rgb_width(COLOR_BITS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [GRID_H-1:0][GRID_W-1:0]  grid,
    input  logic [CXW-1:0]                 cursor_x,
    input  logic [CYW-1:0]                 cursor_y,
    input  logic                           cursor_en,
    input  logic                           lines_en,
    output logic                           hsync,
    output logic                           vsync,
    output logic [CB3-1:0]                 rgb,
    output logic                           de,
    output logic                           frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW = $clog2(H_TOTAL);
    localparam int unsigned VW = $clog2(V_TOTAL);
    localparam int unsigned SW = $clog2(CELL_SIZE);
    localparam int unsigned XW = $clog2(GRID_W + 1);
    localparam int unsigned YW = $clog2(GRID_H + 1);
    localparam logic [SW-1:0] S_LAST = SW'(CELL_SIZE - 1);
    localparam logic [XW-1:0] GW_C = XW'(GRID_W);
    localparam logic [YW-1:0] GH_C = YW'(GRID_H);
    localparam logic [CB3-1:0] C_LIVE = CB3'(LIVE_RGB);
    localparam logic [CB3-1:0] C_DEAD = CB3'(DEAD_RGB);
    localparam logic [CB3-1:0] C_LINE = CB3'(LINE_RGB);
    localparam logic [CB3-1:0] C_CUR  = CB3'(CURSOR_RGB);
    localparam longint unsigned C_MAX = 64'(1) << CB3;

    if (CELL_SIZE < 2 || COLOR_BITS < 1 ||
        H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 ||
        LIVE_RGB >= C_MAX || DEAD_RGB >= C_MAX ||
        LINE_RGB >= C_MAX || CURSOR_RGB >= C_MAX) begin : g_bad_params
        $error("vga_grid_renderer: illegal parameter set");
    end

    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic          hs1, vs1, de1, fs1;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk         (clk),
        .rst         (rst),
        .hcnt        (hcnt),
        .vcnt        (vcnt),
        .hs_active   (hs1),
        .vs_active   (vs1),
        .de          (de1),
        .frame_start (fs1)
    );

    logic h_last, v_last;
    assign h_last = (hcnt == HW'(H_TOTAL - 1));
    assign v_last = (vcnt == VW'(V_TOTAL - 1));

    // Cell counters saturate at GRID_W/GRID_H: that value marks the
    // remainder strip and the blanking interval as "outside the grid".
    logic [SW-1:0] sub_x, sub_y;
    logic [XW-1:0] cell_x;
    logic [YW-1:0] cell_y;

    always_ff @(posedge clk) begin
        if (rst) begin
            sub_x  <= '0;
            sub_y  <= '0;
            cell_x <= '0;
            cell_y <= '0;
        end else if (h_last) begin
            sub_x  <= '0;
            cell_x <= '0;
            if (v_last) begin
                sub_y  <= '0;
                cell_y <= '0;
            end else if (sub_y == S_LAST) begin
                sub_y <= '0;
                if (cell_y != GH_C)
                    cell_y <= cell_y + 1'b1;
            end else begin
                sub_y <= sub_y + 1'b1;
            end
        end else if (sub_x == S_LAST) begin
            sub_x <= '0;
            if (cell_x != GW_C)
                cell_x <= cell_x + 1'b1;
        end else begin
            sub_x <= sub_x + 1'b1;
        end
    end

    // Shadow copy taken on the last pixel of the frame so a whole frame
    // always shows one consistent generation.
    logic [GRID_H-1:0][GRID_W-1:0] shadow;

    always_ff @(posedge clk) begin
        if (rst)
            shadow <= '0;
        else if (h_last && v_last)
            shadow <= grid;
    end

    logic in_grid, on_edge, cur_hit;
    assign in_grid = (cell_x < GW_C) && (cell_y < GH_C);
    assign on_edge = (sub_x == '0) || (sub_x == S_LAST) ||
                     (sub_y == '0) || (sub_y == S_LAST);
    assign cur_hit = (32'(cursor_x) == 32'(cell_x)) &&
                     (32'(cursor_y) == 32'(cell_y));

    logic live1, line1, cur1;

    always_ff @(posedge clk) begin
        if (rst) begin
            live1 <= 1'b0;
            line1 <= 1'b0;
            cur1  <= 1'b0;
        end else begin
            live1 <= in_grid && shadow[cell_y][cell_x];
            line1 <= in_grid && lines_en &&
                     ((sub_x == '0) || (sub_y == '0));
            cur1  <= in_grid && cursor_en && cur_hit && on_edge;
        end
    end

    logic [CB3-1:0] pix;

    always_comb begin
        pix = '0;
        if (!de1)
            pix = '0;
        else if (cur1)
            pix = C_CUR;
        else if (line1)
            pix = C_LINE;
        else if (live1)
            pix = C_LIVE;
        else
            pix = C_DEAD;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
            rgb         <= '0;
            de          <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hsync       <= hs1 ? HSYNC_POL : ~HSYNC_POL;
            vsync       <= vs1 ? VSYNC_POL : ~VSYNC_POL;
            rgb         <= pix;
            de          <= de1;
            frame_start <= fs1;
        end
    end

endmodule

// File: tb/tb_vga_grid_renderer.sv
// Self-checking bench for vga_grid_renderer on a reduced timing set
// with remainder pixels, 2-bit colour and mixed sync polarity.
module tb_vga_grid_renderer;

    localparam int HA = 44, HF = 4, HS = 6, HB = 6;
    localparam int VA = 26, VF = 2, VS = 3, VB = 3;
    localparam int CS = 8, CB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam int GW = HA / CS;
    localparam int GH = VA / CS;
    localparam bit HP = 1'b0;
    localparam bit VP = 1'b1;
    localparam int LIVE = 'h33;
    localparam int DEAD = 'h04;
    localparam int LINE = 'h0d;
    localparam int CUR  = 'h3f;

    typedef struct packed {
        logic [2:0] cx;
        logic [1:0] cy;
        logic       ce;
        logic       le;
    } in_t;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [GH-1:0][GW-1:0]   grid;
    logic [2:0]              cursor_x;
    logic [1:0]              cursor_y;
    logic                    cursor_en;
    logic                    lines_en;
    logic                    hsync, vsync, de, frame_start;
    logic [3*CB-1:0]         rgb;

    int checks = 0;
    int errors = 0;

    int  n;
    int  valid;
    in_t in_prev;
    logic [GH-1:0][GW-1:0] cur_sh, next_sh;

    always #5 clk = ~clk;

    vga_grid_renderer #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .HSYNC_POL (HP), .VSYNC_POL (VP),
        .CELL_SIZE (CS), .COLOR_BITS (CB),
        .LIVE_RGB (LIVE), .DEAD_RGB (DEAD),
        .LINE_RGB (LINE), .CURSOR_RGB (CUR)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .grid        (grid),
        .cursor_x    (cursor_x),
        .cursor_y    (cursor_y),
        .cursor_en   (cursor_en),
        .lines_en    (lines_en),
        .hsync       (hsync),
        .vsync       (vsync),
        .rgb         (rgb),
        .de          (de),
        .frame_start (frame_start)
    );

    function automatic int exp_rgb(int x, int y,
                                   logic [GH-1:0][GW-1:0] sh, in_t i);
        int cx, cy, sx, sy;
        if (!(x < HA && y < VA)) return 0;
        cx = x / CS; cy = y / CS;
        sx = x % CS; sy = y % CS;
        if (cx >= GW || cy >= GH) return DEAD;
        if (i.ce && cx == int'(i.cx) && cy == int'(i.cy) &&
            (sx == 0 || sx == CS - 1 || sy == 0 || sy == CS - 1))
            return CUR;
        if (i.le && (sx == 0 || sy == 0)) return LINE;
        if (sh[cy][cx]) return LIVE;
        return DEAD;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s n=%0d observed=%0h expected=%0h",
                   tag, n, obs, expv);
        end
    endtask

    // One clock: advance the reference position, then compare all pins.
    task automatic step();
        in_t  in_cur;
        logic rst_s;
        logic [GH-1:0][GW-1:0] grid_s;
        int   k, x, y;
        logic e_hs, e_vs, e_de, e_fs;
        int   e_rgb;
        in_cur = '{cursor_x, cursor_y, cursor_en, lines_en};
        rst_s  = rst;
        grid_s = grid;
        @(posedge clk);
        #1;
        if (rst_s) begin
            n = 0; valid = 0;
            cur_sh = '0; next_sh = '0;
        end else begin
            if (n % FT == FT - 1) next_sh = grid_s;
            n++;
            if (valid < 2) valid++;
        end
        if (valid < 2) begin
            e_hs = ~HP; e_vs = ~VP; e_de = 1'b0;
            e_fs = 1'b0; e_rgb = 0;
        end else begin
            k = n - 2;
            x = k % HT;
            y = (k / HT) % VT;
            if (x == 0 && y == 0) cur_sh = next_sh;
            e_hs = (x >= HA + HF && x < HA + HF + HS) ? HP : ~HP;
            e_vs = (y >= VA + VF && y < VA + VF + VS) ? VP : ~VP;
            e_de = (x < HA && y < VA);
            e_fs = (x == 0 && y == 0);
            e_rgb = exp_rgb(x, y, cur_sh, in_prev);
        end
        in_prev = in_cur;
        chk("hsync", 32'(hsync), 32'(e_hs));
        chk("vsync", 32'(vsync), 32'(e_vs));
        chk("de", 32'(de), 32'(e_de));
        chk("frame_start", 32'(frame_start), 32'(e_fs));
        chk("rgb", 32'(rgb), 32'(e_rgb));
        if (errors >= 20) begin
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    endtask

    initial begin
        int guard;
        grid = '0; cursor_x = '0; cursor_y = '0;
        cursor_en = 1'b0; lines_en = 1'b0;
        in_prev = '0; n = 0; valid = 0;
        cur_sh = '0; next_sh = '0;

        repeat (4) step();

        grid[0][0] = 1'b1;
        grid[GH-1][GW-1] = 1'b1;
        rst = 1'b0;
        repeat (2 * FT + 10) step();

        for (int f = 0; f < 6; f++) begin
            for (int c = 0; c < FT; c++) begin
                if (c % 97 == 0) begin
                    cursor_x  = 3'($urandom_range(0, 7));
                    cursor_y  = 2'($urandom_range(0, 3));
                    cursor_en = 1'($urandom);
                    lines_en  = 1'($urandom);
                end
                if (c == FT / 2) grid = 15'($urandom);
                step();
            end
        end

        cursor_x = 3'd1; cursor_y = 2'd1;
        cursor_en = 1'b1; lines_en = 1'b1;
        repeat (FT) step();

        cursor_x = 3'd5;
        repeat (FT) step();

        guard = 0;
        while (n % FT != 15 * HT + 20 && guard < 2 * FT) begin
            step();
            guard++;
        end
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        grid = 15'($urandom);
        repeat (2 * FT + 10) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
